// File: rtl/dco_gen.sv
// dco_gen: programmable square-wave generator with one-cycle phase advance/retard trimming.
module dco_gen #(
    parameter int WIDTH          = 16,
    parameter int DEFAULT_PERIOD = 50
) (
    input  logic             clk_50K,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] period,
    input  logic             load,
    input  logic             advance,
    input  logic             retard,
    output logic             signal_out,
    output logic             edge_pulse
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d, per_act_q, per_act_d, per_pend_q, per_pend_d;
    logic             pend_valid_q, pend_valid_d, signal_out_q, signal_out_d, edge_pulse_q, edge_pulse_d;
    logic [1:0]       step;
    logic [WIDTH:0]   sum;
    logic             wrap;

    assign step = (advance && !retard) ? 2'd2 : (retard && !advance) ? 2'd0 : 2'd1;
    assign sum  = {1'b0, cnt_q} + (WIDTH+1)'(step);
    assign wrap = sum >= {1'b0, per_act_q};

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        per_act_d    = per_act_q;
        per_pend_d   = per_pend_q;
        pend_valid_d = pend_valid_q;
        signal_out_d = 1'b0;
        edge_pulse_d = 1'b0;
        if (state_q == IDLE) begin
            if (enable) begin
                state_d      = RUN;
                signal_out_d = 1'b1;
                edge_pulse_d = 1'b1;
                per_act_d    = pend_valid_q ? per_pend_q : per_act_q;
                pend_valid_d = 1'b0;
            end
        end else if (!enable) begin
            state_d = IDLE;
        end else begin
            if (wrap) begin
                edge_pulse_d = 1'b1;
                per_act_d    = pend_valid_q ? per_pend_q : per_act_q;
                pend_valid_d = 1'b0;
            end else begin
                cnt_d = sum[WIDTH-1:0];
            end
            signal_out_d = cnt_d < (per_act_d >> 1);
        end
        // a load in the same cycle as a wrap stays pending for the following period
        if (load) begin
            per_pend_d   = (period < WIDTH'(2)) ? WIDTH'(2) : period;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_50K or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            per_act_q    <= WIDTH'(DEFAULT_PERIOD);
            per_pend_q   <= WIDTH'(DEFAULT_PERIOD);
            pend_valid_q <= 1'b0;
            signal_out_q <= 1'b0;
            edge_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            per_act_q    <= per_act_d;
            per_pend_q   <= per_pend_d;
            pend_valid_q <= pend_valid_d;
            signal_out_q <= signal_out_d;
            edge_pulse_q <= edge_pulse_d;
        end
    end

    assign signal_out = signal_out_q;
    assign edge_pulse = edge_pulse_q;
endmodule

// File: tb/tb_dco_gen.sv
// tb_dco_gen: scoreboard bench; expected waveform is built from counter positions per period.
module tb_dco_gen;
    logic        clk_50K = 1'b0;
    logic        rst_n, enable, load, advance, retard;
    logic [15:0] period;
    logic        signal_out, edge_pulse;
    logic        ld_n, adv_n, ret_n;
    logic [15:0] per_n;
    logic [1:0]  exp_q[$];
    int          n_chk = 0, n_pass = 0;

    dco_gen #(.WIDTH(16), .DEFAULT_PERIOD(50)) dut (
        .clk_50K(clk_50K), .rst_n(rst_n), .enable(enable), .period(period), .load(load),
        .advance(advance), .retard(retard), .signal_out(signal_out), .edge_pulse(edge_pulse)
    );

    always #10 clk_50K = ~clk_50K;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    always @(posedge clk_50K) begin
        logic [1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("signal_out", {31'd0, signal_out}, {31'd0, e[1]});
            chk("edge_pulse", {31'd0, edge_pulse}, {31'd0, e[0]});
        end
    end

    // one clock edge: drive inputs, push the outputs expected after that edge
    task automatic cyc(input logic en_v, input logic es, input logic ee);
        enable  = en_v;
        load    = ld_n;
        period  = per_n;
        advance = adv_n;
        retard  = ret_n;
        exp_q.push_back({es, ee});
        ld_n  = 1'b0;
        adv_n = 1'b0;
        ret_n = 1'b0;
        @(posedge clk_50K);
        #2;
    endtask

    // one period of P; strobes are raised in the cycle the counter sits at the given position
    task automatic run_per(input int p, input int adv_at = -1, input int ret_at = -1,
                           input int ld_at = -1, input int ld_val = 0, input int stop = 100000);
        int   c, nx, h, n;
        logic a, r, ua, ur;
        h  = p / 2;
        c  = 0;
        n  = 1;
        ua = 1'b0;
        ur = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        while (n < stop) begin
            a  = (c == adv_at) && !ua;
            r  = (c == ret_at) && !ur;
            ua = ua | a;
            ur = ur | r;
            if (c == ld_at) begin
                ld_n  = 1'b1;
                per_n = 16'(ld_val);
            end
            adv_n = a;
            ret_n = r;
            nx = c + 1 + int'(a) - int'(r);
            if (nx >= p) break;
            cyc(1'b1, nx < h, 1'b0);
            c = nx;
            n++;
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; advance = 1'b0; retard = 1'b0; period = '0;
        ld_n = 1'b0; adv_n = 1'b0; ret_n = 1'b0; per_n = '0;
        repeat (2) @(posedge clk_50K);
        #2;
        chk("rst_sig", {31'd0, signal_out}, 0);
        chk("rst_edge", {31'd0, edge_pulse}, 0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        run_per(50);
        run_per(50);
        cyc(1'b0, 1'b0, 1'b0);
        ld_n = 1'b1; per_n = 16'd5;
        cyc(1'b0, 1'b0, 1'b0);
        repeat (3) run_per(5);
        cyc(1'b0, 1'b0, 1'b0);
        ld_n = 1'b1; per_n = 16'd0;
        cyc(1'b0, 1'b0, 1'b0);
        repeat (3) run_per(2);
        cyc(1'b0, 1'b0, 1'b0);
        ld_n = 1'b1; per_n = 16'd8;
        cyc(1'b0, 1'b0, 1'b0);
        run_per(8, -1, -1, 2, 4);
        run_per(4);
        run_per(4, -1, -1, 1, 10);
        run_per(10);
        run_per(10, 3);
        run_per(10);
        run_per(10, -1, 7);
        run_per(10, 3, 3);
        run_per(10, 9);
        run_per(10);
        run_per(10, -1, 0);
        run_per(10);
        run_per(10, -1, -1, -1, 0, 3);
        cyc(1'b0, 1'b0, 1'b0);
        adv_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        run_per(10);
        run_per(10, -1, -1, 0, 7, 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_sig", {31'd0, signal_out}, 0);
        chk("async_rst_edge", {31'd0, edge_pulse}, 0);
        @(posedge clk_50K);
        #2;
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        run_per(50);
        run_per(50);
        cyc(1'b0, 1'b0, 1'b0);
        @(posedge clk_50K);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dco_gen.md
# dco_gen

Digitally controlled square-wave generator for the DPLL loop, clocked by `clk_50K`. It produces the local `signal_out` waveform whose rising edges are fed back through the edge detector to the phase comparator. It also emits a one-cycle `edge_pulse` at each generated rising edge. Period is programmable. Single-cycle `advance` / `retard` strobes from the loop filter trim phase by one `clk_50K` cycle.

## Interface
- `WIDTH`, 16: width of period counter and period word.
- `DEFAULT_PERIOD`, 50: period (in `clk_50K` cycles) loaded at reset; must be ≥ 2.
- Clock/reset: one clock; reset is asynchronous and active-low. Clock port `clk_50K`, reset port `rst_n`.
- `clk_50K`  in  1  system sample clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  level; 1 = generate waveform, 0 = idle with outputs low.
- `period`  in  WIDTH  requested period in cycles; sampled only when `load` = 1.
- `load`  in  1  one-cycle strobe capturing `period` into the pending register.
- `advance`  in  1  one-cycle strobe; shortens the current period by one cycle.
- `retard`  in  1  one-cycle strobe; lengthens the current period by one cycle.
- `signal_out`  out  1  generated square wave, registered.
- `edge_pulse`  out  1  registered; high exactly in the cycle `signal_out` goes 0→1.

## Operation
- Registers:
  - `cnt` [WIDTH]: phase counter.
  - `per_act`: active period.
  - `per_pend` and `pend_valid`: pending period and its flag.
  - `state`: IDLE or RUN.
- Reset values: `state` = IDLE, `cnt` = 0, `per_act` = `per_pend` = `DEFAULT_PERIOD`, `pend_valid` = 0, `signal_out` = 0, `edge_pulse` = 0.
- `load` (any state): `per_pend` ← max(`period`, 2); `pend_valid` ← 1. Values 0 and 1 clamp to 2. Loads are never dropped; the last load before a wrap wins.
- IDLE:
  - `cnt` held at 0; outputs 0; `advance` / `retard` ignored.
  - On a cycle with `enable` = 1: go to RUN with `cnt` ← 0, `signal_out` ← 1, `edge_pulse` ← 1.
  - If `pend_valid` is set, the pending period is applied at this start (`per_act` ← `per_pend`, `pend_valid` ← 0).
- RUN, `enable` = 1, with P = `per_act`, H = P >> 1:
  - Step: +1 normally; +2 if only `advance`; 0 if only `retard`; +1 if both (they cancel).
  - Wrap: occurs when `cnt` + step ≥ P. Then `cnt` ← 0, `edge_pulse` ← 1, and the pending period is applied (`per_act` ← `per_pend`, `pend_valid` ← 0).
  - No wrap: `cnt` ← `cnt` + step, `edge_pulse` ← 0.
  - `signal_out` ← (next `cnt` < H), evaluated against the `per_act` in force after the update.
  - `retard` with `cnt` = 0 holds the counter but does not re-fire `edge_pulse`. `edge_pulse` fires only on a wrap or on start from IDLE.
  - `advance` with `cnt` = P−1 wraps normally; the extra step is discarded.
- RUN, `enable` = 0: on the next edge go to IDLE with `cnt` ← 0 and `signal_out` = `edge_pulse` = 0. The current period is abandoned.
- Duty: high for H cycles, low for P−H cycles. Odd P gives the low phase one extra cycle.

## Timing
- Start latency: first `signal_out` = 1 and `edge_pulse` = 1 in the cycle after `enable` is first sampled high.
- Steady state: `edge_pulse` recurs every P cycles. It is coincident with each 0→1 transition of `signal_out`, never with a 1→1 hold.
- `load` never alters the period in progress; the new P governs from the cycle after the next wrap.
- Phase correction: one `advance` gives a single period of P−1; one `retard` gives P+1. The following periods return to P.
- Async reset mid-run forces all reset values immediately. Operation resumes from IDLE after `rst_n` deasserts.
- Outputs are glitch-free (all registered); no combinational path from inputs to outputs.

## Test plan
- Reset, then `enable` = 1 with default 50 → `signal_out` high 25 cycles / low 25; `edge_pulse` every 50 cycles, first pulse one cycle after `enable`.
- `load` `period` = 5 while idle, then enable → pattern 1,1,0,0,0 repeating; `load` `period` = 0 → clamped, pattern 1,0.
- Running at P = 8, `load` `period` = 4 at `cnt` = 2 → current period completes with 8 cycles, then 4-cycle periods (1,1,0,0).
- P = 10: `advance` at `cnt` = 3 → that period 9 cycles; `retard` at `cnt` = 7 → 11 cycles; both in the same cycle → 10; `advance` at `cnt` = 9 → 10.
- `retard` in the cycle where `cnt` = 0 → `edge_pulse` stays a single cycle, and the high phase lasts H+1 cycles.
- `rst_n` low mid-period, and separately `enable` dropped mid-period → outputs 0 within one edge (async for reset); after restart the first `edge_pulse` arrives one cycle after `enable`, with `per_act` = `DEFAULT_PERIOD` after reset.
